uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial line, frame configuration and receive results of uart_rx.
// master drives the line and configuration; slave is the receiver.
interface uart_rx_if;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;
    logic       busy;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, Par_Err, Stp_Err, busy
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, Par_Err, Stp_Err, busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8 data bits LSB first, optional even/odd parity,
// one stop bit, 3-sample majority vote around each bit centre.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 8
) (
    input logic      CLK,
    input logic      RST,
    uart_rx_if.slave bus
);
    localparam int unsigned   TW     = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    smp_q, smp_d;
    logic          par_en_q, par_en_d;
    logic          par_typ_q, par_typ_d;
    logic          bad_q, bad_d;
    logic          prev_rx_q, prev_rx_d;
    logic [7:0]    data_q, data_d;
    logic          dv_q, dv_d;

    logic          rx;
    logic          at_wrap;
    logic          at_dec;
    logic          bit_val;
    logic          par_err;
    logic          stp_err;

    assign rx      = bus.RX_IN;
    assign at_wrap = (tick_q == T_LAST);
    assign at_dec  = (tick_q == T_DEC);
    assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx) | (smp_q[1] & rx);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        smp_d     = smp_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        bad_d     = bad_q;
        prev_rx_d = rx;
        data_d    = data_q;
        dv_d      = 1'b0;
        par_err   = 1'b0;
        stp_err   = 1'b0;

        if (state_q != IDLE) begin
            tick_d = at_wrap ? '0 : tick_q + 1'b1;
            if (tick_q == T_S0) smp_d[0] = rx;
            if (tick_q == T_S1) smp_d[1] = rx;
        end

        case (state_q)
            IDLE: begin
                tick_d = '0;
                // The edge cycle itself is tick 0, so START begins at tick 1.
                if (!rx && prev_rx_q) begin
                    state_d = START;
                    tick_d  = TW'(1);
                    bad_d   = 1'b0;
                end
            end
            START: begin
                if (at_dec && bit_val) begin
                    state_d = IDLE;
                end else if (at_wrap) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                end
            end
            DATA: begin
                if (at_dec) shift_d = {bit_val, shift_q[7:1]};
                if (at_wrap) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = par_en_q ? PARITY : STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (at_dec && (bit_val != (^shift_q ^ par_typ_q))) begin
                    par_err = 1'b1;
                    bad_d   = 1'b1;
                end
                if (at_wrap) state_d = STOP;
            end
            STOP: begin
                // Leave at the decision tick so a following start edge is caught.
                if (at_dec) begin
                    stp_err = ~bit_val;
                    state_d = IDLE;
                    if (bit_val && !bad_q) begin
                        dv_d   = 1'b1;
                        data_d = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            smp_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            bad_q     <= 1'b0;
            prev_rx_q <= 1'b1;
            data_q    <= '0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            smp_q     <= smp_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            bad_q     <= bad_d;
            prev_rx_q <= prev_rx_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
        end
    end

    assign bus.P_DATA     = data_q;
    assign bus.Data_Valid = dv_q;
    assign bus.Par_Err    = par_err;
    assign bus.Stp_Err    = stp_err;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: OVERSAMPLE=8 and OVERSAMPLE=16 receivers checked every cycle
// against a per-cycle event schedule derived from frame timing and parity rules.
module tb_uart_rx;
    localparam int MAXC = 8192;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_rx_if if_a ();
    uart_rx_if if_b ();

    uart_rx #(.OVERSAMPLE(8))  dut_a (.CLK(CLK), .RST(RST), .bus(if_a.slave));
    uart_rx #(.OVERSAMPLE(16)) dut_b (.CLK(CLK), .RST(RST), .bus(if_b.slave));

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // expected per-cycle behaviour, index [instance][cycle]
    bit         m_dv   [0:1][0:MAXC-1];
    bit         m_pe   [0:1][0:MAXC-1];
    bit         m_se   [0:1][0:MAXC-1];
    bit         m_busy [0:1][0:MAXC-1];
    bit         m_dupd [0:1][0:MAXC-1];
    logic [7:0] m_dval [0:1][0:MAXC-1];
    logic [7:0] m_data [0:1];

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    int dv_cnt [0:1];
    int pe_cnt [0:1];
    int se_cnt [0:1];
    int last_dv [0:1];

    task automatic chk(input string name, input int inst, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[inst %0d] cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    endtask

    function automatic int os_of(input int inst);
        return (inst == 0) ? 8 : 16;
    endfunction

    // decision cycle of bit k (0 = start) for a frame whose falling edge is at c0
    function automatic int dec_cyc(input int inst, input int c0, input int k);
        return c0 + k * os_of(inst) + os_of(inst) / 2 + 1;
    endfunction

    task automatic sched_frame(input int inst, input int c0, input logic [7:0] d,
                               input bit pe, input bit pt, input bit pbit, input bit stop);
        int s = pe ? 10 : 9;
        int ds = dec_cyc(inst, c0, s);
        bit perr = pe && ((($countones(d) + int'(pbit)) % 2) != int'(pt));
        for (int c = c0 + 1; c <= ds; c++) m_busy[inst][c] = 1'b1;
        if (perr) m_pe[inst][dec_cyc(inst, c0, 9)] = 1'b1;
        if (!stop) m_se[inst][ds] = 1'b1;
        if (!perr && stop) begin
            m_dv[inst][ds + 1]   = 1'b1;
            m_dupd[inst][ds + 1] = 1'b1;
            m_dval[inst][ds + 1] = d;
        end
    endtask

    task automatic sched_glitch(input int inst, input int c0);
        for (int c = c0 + 1; c <= dec_cyc(inst, c0, 0); c++) m_busy[inst][c] = 1'b1;
    endtask

    task automatic model_reset(input int r);
        for (int i = 0; i < 2; i++) begin
            for (int c = r + 1; c < r + 400 && c < MAXC; c++) begin
                m_dv[i][c] = 1'b0; m_pe[i][c] = 1'b0; m_se[i][c] = 1'b0;
                m_busy[i][c] = 1'b0; m_dupd[i][c] = 1'b0;
            end
            m_dupd[i][r + 1] = 1'b1;
            m_dval[i][r + 1] = 8'h00;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_line(input int inst, input logic v);
        if (inst == 0) if_a.RX_IN = v;
        else if_b.RX_IN = v;
    endtask

    task automatic set_cfg(input int inst, input logic pe, input logic pt);
        if (inst == 0) begin if_a.PAR_EN = pe; if_a.PAR_TYP = pt; end
        else begin if_b.PAR_EN = pe; if_b.PAR_TYP = pt; end
    endtask

    task automatic idle(input int n);
        set_line(0, 1'b1);
        set_line(1, 1'b1);
        repeat (n) step();
    endtask

    // Drives one whole frame starting with the falling edge in the current cycle.
    // The configuration inputs are inverted mid-frame; the receiver must ignore that.
    task automatic send_frame(input int inst, input logic [7:0] d, input bit pe, input bit pt,
                              input bit pbit, input bit stop, output int c0);
        int   os = os_of(inst);
        int   nb;
        logic bits [0:10];
        bits[0] = 1'b0;
        for (int j = 0; j < 8; j++) bits[j + 1] = d[j];
        nb = 9;
        if (pe) begin bits[9] = pbit; nb = 10; end
        bits[nb] = stop;
        nb++;
        set_cfg(inst, pe, pt);
        c0 = cyc;
        sched_frame(inst, c0, d, pe, pt, pbit, stop);
        for (int k = 0; k < nb; k++) begin
            for (int t = 0; t < os; t++) begin
                set_line(inst, bits[k]);
                if (k == 1 && t == 2) set_cfg(inst, !pe, !pt);
                step();
            end
        end
        set_line(inst, 1'b1);
        set_cfg(inst, pe, pt);
    endtask

    logic [7:0] a_pd;
    logic       a_dv, a_pe, a_se, a_bz;

    always @(negedge CLK) begin
        if (chk_en && cyc < MAXC) begin
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin
                    a_pd = if_a.P_DATA; a_dv = if_a.Data_Valid; a_pe = if_a.Par_Err;
                    a_se = if_a.Stp_Err; a_bz = if_a.busy;
                end else begin
                    a_pd = if_b.P_DATA; a_dv = if_b.Data_Valid; a_pe = if_b.Par_Err;
                    a_se = if_b.Stp_Err; a_bz = if_b.busy;
                end
                if (m_dupd[i][cyc]) m_data[i] = m_dval[i][cyc];
                chk("Data_Valid", i, a_dv, m_dv[i][cyc]);
                chk("Par_Err", i, a_pe, m_pe[i][cyc]);
                chk("Stp_Err", i, a_se, m_se[i][cyc]);
                chk("busy", i, a_bz, m_busy[i][cyc]);
                chk("P_DATA", i, a_pd, m_data[i]);
                if (a_dv === 1'b1) begin dv_cnt[i]++; last_dv[i] = cyc; end
                if (a_pe === 1'b1) pe_cnt[i]++;
                if (a_se === 1'b1) se_cnt[i]++;
            end
        end
    end

    initial begin
        int c0, c1, r, dv0, pe0, se0;
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 8'h00; dv_cnt[i] = 0; pe_cnt[i] = 0; se_cnt[i] = 0; last_dv[i] = 0;
        end
        set_line(0, 1'b1); set_line(1, 1'b1);
        set_cfg(0, 1'b0, 1'b0); set_cfg(1, 1'b0, 1'b0);
        RST = 1'b1;
        step();
        chk_en = 1'b1;
        chk("reset P_DATA", 0, if_a.P_DATA, 8'h00);
        chk("reset busy", 0, if_a.busy, 0);
        chk("reset Data_Valid", 1, if_b.Data_Valid, 0);
        chk("reset busy", 1, if_b.busy, 0);
        step(); step();
        RST = 1'b0;
        idle(4);

        // plain frame, no parity
        dv0 = dv_cnt[0]; pe0 = pe_cnt[0]; se0 = se_cnt[0];
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, c0);
        chk("A5 P_DATA", 0, if_a.P_DATA, 8'hA5);
        chk("A5 dv count", 0, dv_cnt[0] - dv0, 1);
        chk("A5 latency", 0, last_dv[0] - c0, 78);
        chk("A5 err count", 0, pe_cnt[0] + se_cnt[0] - pe0 - se0, 0);
        chk("A5 busy after", 0, if_a.busy, 0);
        idle(5);

        // even parity, correct then wrong parity bit
        send_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, c0);
        chk("3C P_DATA", 0, if_a.P_DATA, 8'h3C);
        chk("3C latency", 0, last_dv[0] - c0, 86);
        idle(3);
        dv0 = dv_cnt[0]; pe0 = pe_cnt[0];
        send_frame(0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, c0);
        chk("3C bad par count", 0, pe_cnt[0] - pe0, 1);
        chk("3C bad dv count", 0, dv_cnt[0] - dv0, 0);
        chk("3C bad P_DATA held", 0, if_a.P_DATA, 8'h3C);
        idle(3);

        // odd parity: 0x01 needs parity bit 0, so bit 1 is a parity error; stop low too
        dv0 = dv_cnt[0]; pe0 = pe_cnt[0]; se0 = se_cnt[0];
        send_frame(0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, c0);
        chk("01 par count", 0, pe_cnt[0] - pe0, 1);
        chk("01 stp count", 0, se_cnt[0] - se0, 1);
        chk("01 dv count", 0, dv_cnt[0] - dv0, 0);
        idle(12);
        pe0 = pe_cnt[0]; se0 = se_cnt[0];
        send_frame(0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, c0);
        chk("01 good par count", 0, pe_cnt[0] - pe0, 0);
        chk("01 stp only count", 0, se_cnt[0] - se0, 1);
        idle(12);

        // 3-cycle glitch, then a real frame
        dv0 = dv_cnt[0]; pe0 = pe_cnt[0]; se0 = se_cnt[0];
        c0 = cyc;
        sched_glitch(0, c0);
        set_line(0, 1'b0);
        repeat (3) step();
        idle(10);
        chk("glitch busy", 0, if_a.busy, 0);
        chk("glitch pulses", 0, dv_cnt[0] + pe_cnt[0] + se_cnt[0] - dv0 - pe0 - se0, 0);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, c0);
        chk("5A P_DATA", 0, if_a.P_DATA, 8'h5A);
        chk("5A dv count", 0, dv_cnt[0] - dv0, 1);
        idle(5);

        // back-to-back frames at OVERSAMPLE=16
        dv0 = dv_cnt[1];
        send_frame(1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, c0);
        chk("11 P_DATA", 1, if_b.P_DATA, 8'h11);
        send_frame(1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, c1);
        chk("EE P_DATA", 1, if_b.P_DATA, 8'hEE);
        chk("b2b dv count", 1, dv_cnt[1] - dv0, 2);
        chk("EE latency", 1, last_dv[1] - c1, 154);
        chk("b2b gap", 1, c1 - c0, 160);
        idle(5);

        // reset during data bit 4 of 0xFF
        dv0 = dv_cnt[0];
        c0 = cyc;
        sched_frame(0, c0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        set_line(0, 1'b0);
        repeat (8) step();
        set_line(0, 1'b1);
        repeat (35) step();
        RST = 1'b1;
        r = cyc;
        model_reset(r);
        step();
        RST = 1'b0;
        chk("rst busy", 0, if_a.busy, 0);
        chk("rst P_DATA", 0, if_a.P_DATA, 8'h00);
        chk("rst P_DATA", 1, if_b.P_DATA, 8'h00);
        idle(100);
        chk("rst dv count", 0, dv_cnt[0] - dv0, 0);
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, c0);
        chk("42 P_DATA", 0, if_a.P_DATA, 8'h42);
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
